// File: rtl/ultrasonic_tx_burst.sv
// Tone-burst generator for one of four ultrasonic transducers: quarter-wave LUT DDS,
// start/busy/txdone handshake and a forced-silent guard interval after each burst.
module ultrasonic_tx_burst #(
    parameter int GUARDLEN = 100,
    parameter int PHW      = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        endata,
    input  logic        start,
    input  logic [1:0]  txsel,
    input  logic [15:0] freqword,
    input  logic [7:0]  ncycles,
    input  logic [1:0]  txscale,
    output logic [11:0] tx1,
    output logic [11:0] tx2,
    output logic [11:0] tx3,
    output logic [11:0] tx4,
    output logic [3:0]  txen,
    output logic        busy,
    output logic        txdone
);
    localparam int GW = (GUARDLEN > 1) ? $clog2(GUARDLEN) : 1;

    typedef enum logic [1:0] {IDLE, ARMED, BURST, GUARD} state_t;

    state_t            state;
    logic [1:0]        sel_q;
    logic [1:0]        scale_q;
    logic [PHW-1:0]    fw_q;
    logic [PHW-1:0]    phase;
    logic [7:0]        n_q;
    logic [7:0]        cnt;
    logic [GW-1:0]     gcnt;

    logic [6:0]        lut_addr;
    logic [10:0]       mag;
    logic signed [11:0] sine;
    logic signed [11:0] sample;

    // round(2047*sin(pi*k/128)) for k = 0..64
    function automatic logic [10:0] quarter_sine(input logic [6:0] k);
        case (k)
            7'd0:  quarter_sine = 11'd0;    7'd1:  quarter_sine = 11'd50;
            7'd2:  quarter_sine = 11'd100;  7'd3:  quarter_sine = 11'd151;
            7'd4:  quarter_sine = 11'd201;  7'd5:  quarter_sine = 11'd251;
            7'd6:  quarter_sine = 11'd300;  7'd7:  quarter_sine = 11'd350;
            7'd8:  quarter_sine = 11'd399;  7'd9:  quarter_sine = 11'd449;
            7'd10: quarter_sine = 11'd497;  7'd11: quarter_sine = 11'd546;
            7'd12: quarter_sine = 11'd594;  7'd13: quarter_sine = 11'd642;
            7'd14: quarter_sine = 11'd690;  7'd15: quarter_sine = 11'd737;
            7'd16: quarter_sine = 11'd783;  7'd17: quarter_sine = 11'd830;
            7'd18: quarter_sine = 11'd875;  7'd19: quarter_sine = 11'd920;
            7'd20: quarter_sine = 11'd965;  7'd21: quarter_sine = 11'd1009;
            7'd22: quarter_sine = 11'd1052; 7'd23: quarter_sine = 11'd1095;
            7'd24: quarter_sine = 11'd1137; 7'd25: quarter_sine = 11'd1179;
            7'd26: quarter_sine = 11'd1219; 7'd27: quarter_sine = 11'd1259;
            7'd28: quarter_sine = 11'd1299; 7'd29: quarter_sine = 11'd1337;
            7'd30: quarter_sine = 11'd1375; 7'd31: quarter_sine = 11'd1411;
            7'd32: quarter_sine = 11'd1447; 7'd33: quarter_sine = 11'd1483;
            7'd34: quarter_sine = 11'd1517; 7'd35: quarter_sine = 11'd1550;
            7'd36: quarter_sine = 11'd1582; 7'd37: quarter_sine = 11'd1614;
            7'd38: quarter_sine = 11'd1644; 7'd39: quarter_sine = 11'd1674;
            7'd40: quarter_sine = 11'd1702; 7'd41: quarter_sine = 11'd1729;
            7'd42: quarter_sine = 11'd1756; 7'd43: quarter_sine = 11'd1781;
            7'd44: quarter_sine = 11'd1805; 7'd45: quarter_sine = 11'd1828;
            7'd46: quarter_sine = 11'd1850; 7'd47: quarter_sine = 11'd1871;
            7'd48: quarter_sine = 11'd1891; 7'd49: quarter_sine = 11'd1910;
            7'd50: quarter_sine = 11'd1927; 7'd51: quarter_sine = 11'd1944;
            7'd52: quarter_sine = 11'd1959; 7'd53: quarter_sine = 11'd1973;
            7'd54: quarter_sine = 11'd1986; 7'd55: quarter_sine = 11'd1997;
            7'd56: quarter_sine = 11'd2008; 7'd57: quarter_sine = 11'd2017;
            7'd58: quarter_sine = 11'd2025; 7'd59: quarter_sine = 11'd2032;
            7'd60: quarter_sine = 11'd2037; 7'd61: quarter_sine = 11'd2041;
            7'd62: quarter_sine = 11'd2045; 7'd63: quarter_sine = 11'd2046;
            7'd64: quarter_sine = 11'd2047;
            default: quarter_sine = 11'd0;
        endcase
    endfunction

    // Odd quadrants read the table backwards, the upper half-cycle negates.
    always_comb begin
        lut_addr = phase[PHW-2] ? 7'(7'd64 - {1'b0, phase[PHW-3:PHW-8]})
                                : {1'b0, phase[PHW-3:PHW-8]};
        mag      = quarter_sine(lut_addr);
        sine     = phase[PHW-1] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
        sample   = sine >>> scale_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            sel_q   <= '0;
            scale_q <= '0;
            fw_q    <= '0;
            phase   <= '0;
            n_q     <= '0;
            cnt     <= '0;
            gcnt    <= '0;
            tx1     <= '0;
            tx2     <= '0;
            tx3     <= '0;
            tx4     <= '0;
            txen    <= '0;
            busy    <= 1'b0;
            txdone  <= 1'b0;
        end else begin
            txdone <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (ncycles != 8'd0) begin
                            sel_q   <= txsel;
                            scale_q <= txscale;
                            fw_q    <= PHW'(freqword);
                            n_q     <= ncycles;
                            phase   <= '0;
                            cnt     <= '0;
                            busy    <= 1'b1;
                            state   <= ARMED;
                        end else begin
                            txdone  <= 1'b1;
                        end
                    end
                end
                ARMED: begin
                    if (endata) begin
                        tx1   <= (sel_q == 2'd0) ? sample : '0;
                        tx2   <= (sel_q == 2'd1) ? sample : '0;
                        tx3   <= (sel_q == 2'd2) ? sample : '0;
                        tx4   <= (sel_q == 2'd3) ? sample : '0;
                        phase <= phase + fw_q;
                        cnt   <= 8'd1;
                        txen  <= 4'b0001 << sel_q;
                        state <= BURST;
                    end
                end
                BURST: begin
                    // The strobe after the last sample silences the outputs.
                    if (endata) begin
                        if (cnt < n_q) begin
                            tx1   <= (sel_q == 2'd0) ? sample : '0;
                            tx2   <= (sel_q == 2'd1) ? sample : '0;
                            tx3   <= (sel_q == 2'd2) ? sample : '0;
                            tx4   <= (sel_q == 2'd3) ? sample : '0;
                            phase <= phase + fw_q;
                            cnt   <= cnt + 8'd1;
                        end else begin
                            tx1   <= '0;
                            tx2   <= '0;
                            tx3   <= '0;
                            tx4   <= '0;
                            txen  <= '0;
                            gcnt  <= '0;
                            state <= GUARD;
                        end
                    end
                end
                GUARD: begin
                    if (endata) begin
                        if (gcnt == GW'(GUARDLEN - 1)) begin
                            busy   <= 1'b0;
                            txdone <= 1'b1;
                            state  <= IDLE;
                        end else begin
                            gcnt   <= gcnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ultrasonic_tx_burst.sv
// Randomised self-checking bench for ultrasonic_tx_burst; expected samples come from
// a floating-point sine model of the burst, not from the DUT's table or state machine.
`timescale 1ns/1ps
module tb_ultrasonic_tx_burst;
    localparam int  GUARDLEN = 100;
    localparam int  ENDIV    = 4;
    localparam real PI       = 3.141592653589793;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        endata = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  txsel = '0;
    logic [15:0] freqword = '0;
    logic [7:0]  ncycles = '0;
    logic [1:0]  txscale = '0;
    logic [11:0] tx1, tx2, tx3, tx4;
    logic [3:0]  txen;
    logic        busy, txdone;
    logic [11:0] txv [4];

    int vectors = 0;
    int miscompares = 0;

    ultrasonic_tx_burst #(.GUARDLEN(GUARDLEN), .PHW(16)) dut (
        .clock(clock), .reset(reset), .endata(endata), .start(start),
        .txsel(txsel), .freqword(freqword), .ncycles(ncycles), .txscale(txscale),
        .tx1(tx1), .tx2(tx2), .tx3(tx3), .tx4(tx4),
        .txen(txen), .busy(busy), .txdone(txdone)
    );

    assign txv[0] = tx1;
    assign txv[1] = tx2;
    assign txv[2] = tx3;
    assign txv[3] = tx4;

    always #5 clock = ~clock;

    function automatic int lut_ref(int k);
        return int'($floor(2047.0 * $sin(PI * real'(k) / 128.0) + 0.5));
    endfunction

    // Ideal sample for a 16-bit phase, attenuated by floor division by 2^scale.
    function automatic int golden(int phase, int scale);
        int q = (phase / 16384) % 4;
        int k = (phase / 256) % 64;
        int v;
        case (q)
            0: v = lut_ref(k);
            1: v = lut_ref(64 - k);
            2: v = -lut_ref(k);
            default: v = -lut_ref(64 - k);
        endcase
        return int'($floor(real'(v) / real'(1 << scale)));
    endfunction

    // Channel c after strobe s of a burst: sample s on the selected channel, else 0.
    function automatic logic [11:0] expected_tx(int s, int c, int sel, int fw, int n, int scale);
        if (s >= 0 && s < n && c == sel) return 12'(golden((s * fw) % 65536, scale));
        return 12'd0;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        bit bad;
        reset = 1'b1;
        repeat (3) tick();
        vectors++;
        if ({tx1, tx2, tx3, tx4, txen, busy, txdone} !== 54'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_state: got tx=%h,%h,%h,%h txen=%b busy=%b txdone=%b expected all 0",
                     tx1, tx2, tx3, tx4, txen, busy, txdone);
        end
        reset = 1'b0;
        tick();
        txsel = 2'd2; freqword = 16'd3000; ncycles = 8'd10; txscale = 2'd0;
        start = 1'b1; tick(); start = 1'b0;
        for (int s = 0; s < 4; s++) begin
            repeat (ENDIV - 1) tick();
            endata = 1'b1; tick(); endata = 1'b0;
        end
        vectors++;
        if (tx3 !== expected_tx(3, 2, 2, 3000, 10, 0) || txen !== 4'b0100 || busy !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_burst: got tx3=%0d txen=%b busy=%b expected %0d 0100 1",
                     $signed(tx3), txen, busy, $signed(expected_tx(3, 2, 2, 3000, 10, 0)));
        end
        reset = 1'b1; tick(); reset = 1'b0;
        vectors++;
        if ({tx1, tx2, tx3, tx4, txen, busy, txdone} !== 54'd0) begin
            miscompares++;
            $display("[TB] FAIL midburst_reset: got tx=%h,%h,%h,%h txen=%b busy=%b txdone=%b expected all 0",
                     tx1, tx2, tx3, tx4, txen, busy, txdone);
        end
        bad = 1'b0;
        for (int t = 0; t < 40; t++) begin
            endata = (t % ENDIV == 0);
            tick();
            if ({tx1, tx2, tx3, tx4, txen, busy, txdone} !== 54'd0) bad = 1'b1;
        end
        endata = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL post_reset_quiet: got activity after abort, expected idle outputs and no txdone");
        end
        reset = 1'b1; start = 1'b1; ncycles = 8'd5;
        tick();
        reset = 1'b0; start = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || txdone !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL start_with_reset: got busy=%b txdone=%b expected 0 0", busy, txdone);
        end
    endtask

    // One complete burst and guard, optionally with a stray start at strobe mid_start.
    task automatic test_burst(int sel, int fw, int n, int scale, int mid_start, int armed_wait);
        bit bad;
        logic [3:0] exp_en;
        txsel = 2'(sel); freqword = 16'(fw); ncycles = 8'(n); txscale = 2'(scale);
        start = 1'b1; tick(); start = 1'b0;
        txsel = 2'($urandom); freqword = 16'($urandom); ncycles = 8'($urandom); txscale = 2'($urandom);
        vectors++;
        if (busy !== 1'b1 || txdone !== 1'b0 || txen !== 4'd0) begin
            miscompares++;
            $display("[TB] FAIL accept: got busy=%b txdone=%b txen=%b expected 1 0 0000", busy, txdone, txen);
        end
        repeat (armed_wait) tick();
        vectors++;
        if (busy !== 1'b1 || txen !== 4'd0 || {tx1, tx2, tx3, tx4} !== 48'd0) begin
            miscompares++;
            $display("[TB] FAIL armed: got busy=%b txen=%b tx=%h,%h,%h,%h expected 1 0000 zeros",
                     busy, txen, tx1, tx2, tx3, tx4);
        end
        for (int s = 0; s < n + 1 + GUARDLEN; s++) begin
            for (int g = 0; g < ENDIV - 1; g++) begin
                if (s == mid_start && g == 0) begin
                    ncycles = 8'($urandom_range(1, 255));
                    start = 1'b1;
                end
                tick();
                start = 1'b0;
            end
            bad = (txdone !== 1'b0);
            for (int c = 0; c < 4; c++)
                if (txv[c] !== expected_tx(s - 1, c, sel, fw, n, scale)) bad = 1'b1;
            vectors++;
            if (bad) begin
                miscompares++;
                $display("[TB] FAIL hold before strobe %0d: got tx=%0d,%0d,%0d,%0d txdone=%b expected held strobe %0d, txdone 0",
                         s, $signed(tx1), $signed(tx2), $signed(tx3), $signed(tx4), txdone, s - 1);
            end
            endata = 1'b1; tick(); endata = 1'b0;
            bad = 1'b0;
            for (int c = 0; c < 4; c++)
                if (txv[c] !== expected_tx(s, c, sel, fw, n, scale)) bad = 1'b1;
            vectors++;
            if (bad) begin
                miscompares++;
                $display("[TB] FAIL sample strobe %0d: got tx=%0d,%0d,%0d,%0d expected %0d,%0d,%0d,%0d", s,
                         $signed(tx1), $signed(tx2), $signed(tx3), $signed(tx4),
                         $signed(expected_tx(s, 0, sel, fw, n, scale)), $signed(expected_tx(s, 1, sel, fw, n, scale)),
                         $signed(expected_tx(s, 2, sel, fw, n, scale)), $signed(expected_tx(s, 3, sel, fw, n, scale)));
            end
            exp_en = (s < n) ? 4'(1 << sel) : 4'd0;
            vectors++;
            if (txen !== exp_en || busy !== (s < n + GUARDLEN) || txdone !== (s == n + GUARDLEN)) begin
                miscompares++;
                $display("[TB] FAIL control strobe %0d: got txen=%b busy=%b txdone=%b expected %b %b %b",
                         s, txen, busy, txdone, exp_en, (s < n + GUARDLEN), (s == n + GUARDLEN));
            end
        end
        tick();
        vectors++;
        if (txdone !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL txdone_width: got txdone=%b busy=%b expected 0 0", txdone, busy);
        end
    endtask

    task automatic test_basic_tone();
        test_burst(1, 16384, 8, 0, -1, 2);
        test_burst(1, 16384, 8, 1, -1, 0);
        test_burst(1, 16384, 8, 3, -1, 1);
    endtask

    task automatic test_handshake();
        test_burst(0, 5000, 4, 2, 2, 5);
        test_burst(2, 1234, 4, 0, 50, 3);
    endtask

    task automatic test_zero_length();
        bit bad;
        txsel = 2'd3; freqword = 16'd9999; ncycles = 8'd0; txscale = 2'd0;
        start = 1'b1; tick(); start = 1'b0;
        vectors++;
        if (txdone !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL zero_len_pulse: got txdone=%b busy=%b expected 1 0", txdone, busy);
        end
        bad = 1'b0;
        for (int t = 0; t < 3 * ENDIV; t++) begin
            endata = (t % ENDIV == 0);
            tick();
            if ({tx1, tx2, tx3, tx4, txen, busy, txdone} !== 54'd0) bad = 1'b1;
        end
        endata = 1'b0;
        vectors++;
        if (bad) begin
            miscompares++;
            $display("[TB] FAIL zero_len_quiet: got activity after zero-length start, expected idle");
        end
    endtask

    task automatic test_wrap_random();
        test_burst(3, 40000, 20, 0, -1, 0);
        test_burst(3, 40000, 20, 1, -1, 0);
        repeat (6) begin
            test_burst(int'($urandom_range(0, 3)), int'($urandom_range(1, 65535)),
                       int'($urandom_range(1, 40)), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 30)), int'($urandom_range(0, 5)));
        end
    endtask

    task automatic test_back_to_back();
        test_burst(2, 16384, 8, 0, -1, 0);
        test_burst(0, 777, 3, 2, -1, 0);
    endtask

    initial begin
        test_reset();
        test_basic_tone();
        test_handshake();
        test_zero_length();
        test_wrap_random();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
